pc_gen: RTL and testbench

- Parametrised fetch-address generator; next generation of the CPU's PC register.
- Generalised in address width, reset vector and instruction step.
- Adds a valid/ready handshake to the IF stage and a direct-mapped branch target buffer (BTB) with 2-bit counters.
- Sits at the head of the pipeline. Drives IF; takes redirects and training updates from EX.

---
 rtl/pc_gen_pkg.sv | 23 ++
 rtl/pc_btb.sv | 90 +++++++++
 rtl/pc_gen.sv | 101 ++++++++++
 tb/tb_pc_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-address generator and its branch target buffer.
package pc_gen_pkg;

    localparam int MAX_XLEN = 64;
    localparam logic [MAX_XLEN-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_e;

    function automatic int log2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Combinational read port, synchronous write port, async clear of valid bits.
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 16,
    parameter int STEP      = 4
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [XLEN-1:0] rd_pc_in,
    output logic            rd_taken_out,
    output logic [XLEN-1:0] rd_target_out,
    input  logic            wr_en_in,
    input  logic [XLEN-1:0] wr_pc_in,
    input  logic            wr_taken_in,
    input  logic [XLEN-1:0] wr_target_in
);

    localparam int OFF_W = log2_f(STEP);
    localparam int IDX_W = log2_f(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX_W - OFF_W;

    logic [BTB_DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
    logic [XLEN-1:0]      target_q [BTB_DEPTH];
    logic [1:0]           ctr_q    [BTB_DEPTH];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             rd_hit, wr_hit;
    logic             entry_we;
    logic [XLEN-1:0]  entry_target_d;
    logic [1:0]       entry_ctr_d;
    logic             unused_low_bits;

    assign rd_idx = rd_pc_in[OFF_W +: IDX_W];
    assign rd_tag = rd_pc_in[XLEN-1 -: TAG_W];
    assign wr_idx = wr_pc_in[OFF_W +: IDX_W];
    assign wr_tag = wr_pc_in[XLEN-1 -: TAG_W];
    assign unused_low_bits = ^{rd_pc_in[OFF_W-1:0], wr_pc_in[OFF_W-1:0]};

    always_comb begin
        rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_taken_out  = rd_hit && (ctr_q[rd_idx] >= CTR_WT);
        rd_target_out = rd_taken_out ? target_q[rd_idx] : ZERO_WORD[XLEN-1:0];
    end

    // NOTE: every signal gets a default before the branches so no latch is inferred.
    always_comb begin
        wr_hit         = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        valid_d        = valid_q;
        entry_we       = 1'b0;
        entry_target_d = target_q[wr_idx];
        entry_ctr_d    = ctr_q[wr_idx];
        if (wr_en_in) begin
            if (wr_hit) begin
                entry_we = 1'b1;
                if (wr_taken_in) begin
                    entry_target_d = wr_target_in;
                    if (ctr_q[wr_idx] != CTR_ST) entry_ctr_d = ctr_q[wr_idx] + 2'd1;
                end else if (ctr_q[wr_idx] != CTR_SNT) begin
                    entry_ctr_d = ctr_q[wr_idx] - 2'd1;
                end
            end else if (wr_taken_in) begin
                entry_we        = 1'b1;
                valid_d[wr_idx] = 1'b1;
                entry_target_d  = wr_target_in;
                entry_ctr_d     = CTR_WT;
            end
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // NOTE: payload arrays are deliberately not reset; the valid bits gate every use.
    always_ff @(posedge clk_in) begin
        if (entry_we) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= entry_target_d;
            ctr_q[wr_idx]    <= entry_ctr_d;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: next-PC register, IF handshake and BTB-driven prediction.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}},
    parameter int              STEP      = 4,
    parameter int              BTB_DEPTH = 16
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            fetch_ready_in,
    input  logic            redirect_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    input  logic            update_valid_in,
    input  logic [XLEN-1:0] update_pc_in,
    input  logic            update_taken_in,
    input  logic [XLEN-1:0] update_target_in,
    output logic            fetch_valid_out,
    output logic [XLEN-1:0] fetch_pc_out,
    output logic            pred_taken_out,
    output logic [XLEN-1:0] pred_target_out
);

    localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

    logic [XLEN-1:0] npc_q, npc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            pred_taken_q, pred_taken_d;
    logic [XLEN-1:0] pred_target_q, pred_target_d;

    logic            btb_taken;
    logic [XLEN-1:0] btb_target;
    logic            adv;

    pc_btb #(
        .XLEN      (XLEN),
        .BTB_DEPTH (BTB_DEPTH),
        .STEP      (STEP)
    ) u_btb (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rd_pc_in      (npc_q),
        .rd_taken_out  (btb_taken),
        .rd_target_out (btb_target),
        .wr_en_in      (update_valid_in && rdy_in && !rst_in),
        .wr_pc_in      (update_pc_in),
        .wr_taken_in   (update_taken_in),
        .wr_target_in  (update_target_in)
    );

    assign adv = !fetch_valid_q || fetch_ready_in;

    // Priority: redirect, then advance, otherwise hold.
    always_comb begin
        npc_d         = npc_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc_d    = fetch_pc_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (rdy_in) begin
            if (redirect_in) begin
                fetch_valid_d = 1'b1;
                fetch_pc_d    = redirect_pc_in;
                pred_taken_d  = 1'b0;
                pred_target_d = ZERO_WORD[XLEN-1:0];
                npc_d         = redirect_pc_in + STEP_W;
            end else if (adv) begin
                fetch_valid_d = 1'b1;
                fetch_pc_d    = npc_q;
                pred_taken_d  = btb_taken;
                pred_target_d = btb_target;
                npc_d         = btb_taken ? btb_target : npc_q + STEP_W;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            npc_q         <= RESET_VEC;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= ZERO_WORD[XLEN-1:0];
            pred_taken_q  <= 1'b0;
            pred_target_q <= ZERO_WORD[XLEN-1:0];
        end else begin
            npc_q         <= npc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    assign fetch_valid_out = fetch_valid_q;
    assign fetch_pc_out    = fetch_pc_q;
    assign pred_taken_out  = pred_taken_q;
    assign pred_target_out = pred_target_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver feeds a behavioural model, monitor compares outputs each cycle.
module tb_pc_gen;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_VEC = 32'h0000_0100;
    localparam int          STEP      = 4;
    localparam int          DEPTH     = 16;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        fready = 1'b1;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        upd_v = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_t = 1'b0;
    logic [31:0] upd_tg = '0;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        p_taken;
    logic [31:0] p_target;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    // Reference model state: BTB kept as plain arrays indexed by (pc/STEP) mod DEPTH.
    logic [31:0] m_npc;
    exp_t        m_out;
    bit          m_bv  [DEPTH];
    logic [31:0] m_tag [DEPTH];
    logic [31:0] m_tgt [DEPTH];
    int          m_ctr [DEPTH];

    pc_gen #(
        .XLEN      (XLEN),
        .RESET_VEC (RESET_VEC),
        .STEP      (STEP),
        .BTB_DEPTH (DEPTH)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .rdy_in           (rdy),
        .fetch_ready_in   (fready),
        .redirect_in      (redir),
        .redirect_pc_in   (redir_pc),
        .update_valid_in  (upd_v),
        .update_pc_in     (upd_pc),
        .update_taken_in  (upd_t),
        .update_target_in (upd_tg),
        .fetch_valid_out  (f_valid),
        .fetch_pc_out     (f_pc),
        .pred_taken_out   (p_taken),
        .pred_target_out  (p_target)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / STEP) % DEPTH);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (STEP * DEPTH);
    endfunction

    task automatic model_step(input bit r, input bit rd, input bit fr, input bit rdr,
                              input logic [31:0] rpc, input bit uv, input logic [31:0] upc,
                              input bit ut, input logic [31:0] utg);
        int          li;
        int          ui;
        bit          pred;
        logic [31:0] ptg;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) m_bv[i] = 1'b0;
            m_npc = RESET_VEC;
            m_out = '0;
            return;
        end
        if (!rd) return;
        li   = idx_of(m_npc);
        pred = m_bv[li] && (m_tag[li] == tag_of(m_npc)) && (m_ctr[li] >= 2);
        ptg  = m_tgt[li];
        if (rdr) begin
            m_out.v  = 1'b1;
            m_out.pc = rpc;
            m_out.pt = 1'b0;
            m_out.tg = 32'h0;
            m_npc    = rpc + 32'(STEP);
        end else if (!m_out.v || fr) begin
            m_out.v  = 1'b1;
            m_out.pc = m_npc;
            m_out.pt = pred;
            m_out.tg = pred ? ptg : 32'h0;
            m_npc    = pred ? ptg : m_npc + 32'(STEP);
        end
        if (uv) begin
            ui = idx_of(upc);
            if (m_bv[ui] && m_tag[ui] == tag_of(upc)) begin
                if (ut) begin
                    m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
                    m_tgt[ui] = utg;
                end else begin
                    m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                end
            end else if (ut) begin
                m_bv[ui]  = 1'b1;
                m_tag[ui] = tag_of(upc);
                m_tgt[ui] = utg;
                m_ctr[ui] = 2;
            end
        end
    endtask

    task automatic drive(input bit r, input bit rd, input bit fr, input bit rdr,
                         input logic [31:0] rpc, input bit uv, input logic [31:0] upc,
                         input bit ut, input logic [31:0] utg);
        @(negedge clk);
        rst      = r;
        rdy      = rd;
        fready   = fr;
        redir    = rdr;
        redir_pc = rpc;
        upd_v    = uv;
        upd_pc   = upc;
        upd_t    = ut;
        upd_tg   = utg;
        model_step(r, rd, fr, rdr, rpc, uv, upc, ut, utg);
        exp_q.push_back(m_out);
    endtask

    task automatic idle(input bit fr);
        drive(1'b0, 1'b1, fr, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic jump(input bit fr, input logic [31:0] pc);
        drive(1'b0, 1'b1, fr, 1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] tg);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, pc, taken, tg);
    endtask

    task automatic check(input string name, input exp_t got, input exp_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got v=%0b pc=%h pt=%0b tg=%h, want v=%0b pc=%h pt=%0b tg=%h",
                     name, got.v, got.pc, got.pt, got.tg, want.v, want.pc, want.pt, want.tg);
        end
    endtask

    // Monitor: one expected response per clock edge, compared just after the edge.
    initial begin
        exp_t want;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = '{v: f_valid, pc: f_pc, pt: p_taken, tg: p_target};
                check($sformatf("cycle@%0t", $time), got, want);
            end
        end
    end

    initial begin
        // Reset, then sequential fetch from RESET_VEC.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b1);
        idle(1'b1);
        // Stall at 0x104 for three cycles, then resume.
        repeat (3) idle(1'b0);
        idle(1'b1);
        // Redirect while IF is stalled.
        jump(1'b0, 32'h0000_0400);
        idle(1'b0);
        idle(1'b1);
        // Train a taken branch at 0x10C and fetch through it.
        train(32'h0000_010C, 1'b1, 32'h0000_0200);
        jump(1'b1, 32'h0000_0108);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        // Two not-taken updates drop the prediction.
        train(32'h0000_010C, 1'b0, 32'h0);
        train(32'h0000_010C, 1'b0, 32'h0);
        jump(1'b1, 32'h0000_0108);
        idle(1'b1);
        idle(1'b1);
        // Re-strengthen, then alias at 0x14C evicts 0x10C.
        train(32'h0000_010C, 1'b1, 32'h0000_0200);
        train(32'h0000_010C, 1'b1, 32'h0000_0200);
        jump(1'b1, 32'h0000_0108);
        idle(1'b1);
        train(32'h0000_014C, 1'b1, 32'h0000_0300);
        jump(1'b1, 32'h0000_0108);
        idle(1'b1);
        train(32'h0000_010C, 1'b0, 32'h0);
        jump(1'b1, 32'h0000_0148);
        idle(1'b1);
        idle(1'b1);
        // Global enable low: nothing moves, updates dropped.
        repeat (5) drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0800, 1'b1, 32'h0000_014C, 1'b0, 32'h0);
        jump(1'b1, 32'h0000_0148);
        idle(1'b1);
        // Reset in the middle of a held fetch, then confirm the BTB was cleared.
        repeat (2) idle(1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b1);
        jump(1'b1, 32'h0000_0148);
        idle(1'b1);
        // Address wrap-around.
        jump(1'b1, 32'hFFFF_FFFC);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic over a small address window so the BTB gets hits and aliases.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 149) == 0,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0,
                  32'h100 + 32'($urandom_range(0, 63) << 2),
                  $urandom_range(0, 2) == 0,
                  32'h100 + 32'($urandom_range(0, 63) << 2),
                  1'($urandom_range(0, 1)),
                  32'h100 + 32'($urandom_range(0, 63) << 2));
        end
        idle(1'b1);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d responses still pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
